// File: rtl/ysyx_041461_hazard_scoreboard_pkg.sv
//------------------------------------------------------------------------------
// Module   : ysyx_041461_hazard_scoreboard_pkg
// Purpose  : Shared types and constants for the issue-stage hazard scoreboard:
//            scoreboard FSM state encodings and the "no trap" code.
// Ports    : none (package)
// Config   : none
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ysyx_041461_hazard_scoreboard_pkg;

   // Trap code meaning "no trap" on both the ID and WB trap fields.
   localparam logic [3:0] TRAP_NOP = 4'h0;

   // RUN   : normal issue
   // HOLD  : a trap instruction has issued; wait for it to reach WB
   // FLUSH : one-cycle pipeline flush, scoreboard cleared
   typedef enum logic [1:0] {
      SB_RUN   = 2'd0,
      SB_HOLD  = 2'd1,
      SB_FLUSH = 2'd2
   } sb_state_e;

   function automatic logic is_trap(input logic [3:0] code);
      return code != TRAP_NOP;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_041461_hazard_scoreboard_if.sv
//------------------------------------------------------------------------------
// Module   : ysyx_041461_hazard_scoreboard_if
// Purpose  : Bundle of the ID issue side, WB retire side and scoreboard status
//            signals. The pipeline (ID/WB) is the master, the scoreboard the
//            slave.
// Ports    : id_valid/id_rs1_re/id_rs1/id_rs2_re/id_rs2/id_rd_we/id_rd/id_trap
//            (master->slave), id_ready (slave->master),
//            wb_valid/wb_rd_we/wb_rd/wb_trap (master->slave),
//            flush_out/sb_busy/stall_cnt (slave->master)
// Config   : none
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ysyx_041461_hazard_scoreboard_if #(
   parameter int AW     = 5,
   parameter int PERF_W = 32
);
   logic              id_valid;
   logic              id_rs1_re;
   logic [AW-1:0]     id_rs1;
   logic              id_rs2_re;
   logic [AW-1:0]     id_rs2;
   logic              id_rd_we;
   logic [AW-1:0]     id_rd;
   logic [3:0]        id_trap;
   logic              id_ready;

   logic              wb_valid;
   logic              wb_rd_we;
   logic [AW-1:0]     wb_rd;
   logic [3:0]        wb_trap;

   logic              flush_out;
   logic              sb_busy;
   logic [PERF_W-1:0] stall_cnt;

   modport master (
      output id_valid, id_rs1_re, id_rs1, id_rs2_re, id_rs2, id_rd_we, id_rd, id_trap,
      output wb_valid, wb_rd_we, wb_rd, wb_trap,
      input  id_ready, flush_out, sb_busy, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs1_re, id_rs1, id_rs2_re, id_rs2, id_rd_we, id_rd, id_trap,
      input  wb_valid, wb_rd_we, wb_rd, wb_trap,
      output id_ready, flush_out, sb_busy, stall_cnt
   );
endinterface

`default_nettype wire

// File: rtl/ysyx_041461_hazard_scoreboard_sb_cnt.sv
//------------------------------------------------------------------------------
// Module   : ysyx_041461_sb_cnt
// Purpose  : One pending-write counter of the scoreboard. Saturating up/down
//            counter; simultaneous inc and dec cancel, clear has priority.
// Ports    : clk, rst_n (async, active low)
//            inc_i  - issue of a write to this register
//            dec_i  - retire of a write to this register
//            clr_i  - synchronous clear (pipeline flush)
//            cnt_o  - current count
//            full_o - count at maximum (2**CNT_W-1)
// Config   : none
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ysyx_041461_sb_cnt #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   input  logic             dec_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             full_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !dec_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (dec_i && !inc_i && (cnt_q != '0)) begin
         // A retire with nothing pending is a protocol error; hold at zero
         // rather than wrapping to a bogus "many pending" value.
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign full_o = (cnt_q == CNT_MAX);

   a_no_underflow: assert property (
      @(posedge clk) disable iff (!rst_n)
         !(dec_i && !inc_i && !clr_i && (cnt_q == '0))
   ) else $error("sb_cnt: retire with no pending write");

endmodule

`default_nettype wire

// File: rtl/ysyx_041461_hazard_scoreboard.sv
//------------------------------------------------------------------------------
// Module   : ysyx_041461_hazard_scoreboard
// Purpose  : Counter-based issue scoreboard. Counts in-flight GPR writes per
//            register, stalls ID on RAW hazards or when a destination counter
//            is saturated, and serialises traps (HOLD until the trap reaches
//            WB, then a one-cycle flush that clears all counters).
// Ports    : clk   - clock, rising edge
//            rst_n - asynchronous reset, active low
//            bus   - ysyx_041461_hazard_scoreboard_if.slave (ID issue side,
//                    WB retire side, id_ready/flush_out/sb_busy/stall_cnt)
// Config   : YSYX_041461_SB_PERF_EN - when defined, stall_cnt counts cycles
//            with id_valid & !id_ready (saturating); otherwise tied to 0.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ysyx_041461_hazard_scoreboard
   import ysyx_041461_hazard_scoreboard_pkg::*;
#(
   parameter int NR_REGS = 32,
   parameter int AW      = 5,
   parameter int CNT_W   = 2,
   parameter int PERF_W  = 32
) (
   input logic                            clk,
   input logic                            rst_n,
   ysyx_041461_hazard_scoreboard_if.slave bus
);

   sb_state_e                       state_q;
   sb_state_e                       state_d;
   logic                            ready_en_q;

   logic [NR_REGS-1:0][CNT_W-1:0]   pend;
   logic [NR_REGS-1:0]              full;
   logic [NR_REGS-1:1]              inc;
   logic [NR_REGS-1:1]              dec;

   logic                            id_ready;
   logic                            fire;
   logic                            clr;
   logic                            rs1_haz;
   logic                            rs2_haz;
   logic                            waw_haz;
   logic                            wb_trap_seen;

   // x0 is never tracked: constant zero, never full.
   assign pend[0] = '0;
   assign full[0] = 1'b0;

   assign clr  = (state_q == SB_FLUSH);
   assign fire = bus.id_valid && id_ready;

   for (genvar r = 1; r < NR_REGS; r++) begin : g_cnt
      // A trap instruction issues but its destination is not counted: it
      // will be flushed rather than retired normally.
      assign inc[r] = fire && bus.id_rd_we && !is_trap(bus.id_trap)
                      && (bus.id_rd == AW'(r));
      assign dec[r] = bus.wb_valid && bus.wb_rd_we && (bus.wb_rd == AW'(r));

      ysyx_041461_sb_cnt #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk    (clk),
         .rst_n  (rst_n),
         .inc_i  (inc[r]),
         .dec_i  (dec[r]),
         .clr_i  (clr),
         .cnt_o  (pend[r]),
         .full_o (full[r])
      );
   end

   // Hazards look at registered counters only, so a write retiring in WB is
   // visible to ID one cycle later.
   assign rs1_haz = bus.id_rs1_re && (bus.id_rs1 != '0) && (pend[bus.id_rs1] != '0);
   assign rs2_haz = bus.id_rs2_re && (bus.id_rs2 != '0) && (pend[bus.id_rs2] != '0);
   assign waw_haz = bus.id_rd_we && full[bus.id_rd];

   // ready_en_q keeps id_ready low from reset until the first clock edge.
   assign id_ready = ready_en_q && (state_q == SB_RUN)
                     && !(rs1_haz || rs2_haz || waw_haz);

   assign wb_trap_seen = bus.wb_valid && is_trap(bus.wb_trap);

   always_comb begin
      state_d = state_q;
      case (state_q)
         SB_RUN: begin
            // A trap surfacing at WB wins over a new trap issuing this cycle:
            // the flush discards the younger instruction anyway.
            if (wb_trap_seen) begin
               state_d = SB_FLUSH;
            end else if (fire && is_trap(bus.id_trap)) begin
               state_d = SB_HOLD;
            end
         end
         SB_HOLD: begin
            if (wb_trap_seen) begin
               state_d = SB_FLUSH;
            end
         end
         SB_FLUSH: begin
            state_d = SB_RUN;
         end
         default: begin
            state_d = SB_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= SB_RUN;
         ready_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ready_en_q <= 1'b1;
      end
   end

   assign bus.id_ready  = id_ready;
   assign bus.flush_out = (state_q == SB_FLUSH);
   assign bus.sb_busy   = (|pend) || (state_q != SB_RUN);

`ifdef YSYX_041461_SB_PERF_EN
   logic [PERF_W-1:0] stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (bus.id_valid && !id_ready && (stall_q != '1)) begin
         stall_q <= stall_q + PERF_W'(1);
      end
   end

   assign bus.stall_cnt = stall_q;
`else
   assign bus.stall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_041461_hazard_scoreboard.sv
//------------------------------------------------------------------------------
// Module   : tb_ysyx_041461_hazard_scoreboard
// Purpose  : Directed self-checking bench for the issue hazard scoreboard.
//            Inputs change just after the falling edge; outputs are sampled
//            1 ns later, well away from the rising edge.
// Ports    : none
// Config   : YSYX_041461_SB_PERF_EN selects the expected stall count.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ysyx_041461_hazard_scoreboard;

   localparam logic [3:0] NOP   = 4'h0;
   localparam logic [3:0] ECALL = 4'hB;
   localparam logic [3:0] MEMF  = 4'h3;

`ifdef YSYX_041461_SB_PERF_EN
   localparam logic [31:0] EXP_T1_STALLS = 32'd3;
`else
   localparam logic [31:0] EXP_T1_STALLS = 32'd0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   ysyx_041461_hazard_scoreboard_if #(.AW(5), .PERF_W(32)) bus ();

   ysyx_041461_hazard_scoreboard #(
      .NR_REGS (32),
      .AW      (5),
      .CNT_W   (2),
      .PERF_W  (32)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic id_drive(input logic v, input logic r1e, input logic [4:0] r1,
                           input logic r2e, input logic [4:0] r2,
                           input logic we, input logic [4:0] rd, input logic [3:0] trap);
      bus.id_valid  = v;
      bus.id_rs1_re = r1e;
      bus.id_rs1    = r1;
      bus.id_rs2_re = r2e;
      bus.id_rs2    = r2;
      bus.id_rd_we  = we;
      bus.id_rd     = rd;
      bus.id_trap   = trap;
   endtask

   task automatic wb_drive(input logic v, input logic we, input logic [4:0] rd,
                           input logic [3:0] trap);
      bus.wb_valid = v;
      bus.wb_rd_we = we;
      bus.wb_rd    = rd;
      bus.wb_trap  = trap;
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      id_drive(0, 0, 0, 0, 0, 0, 0, NOP);
      wb_drive(0, 0, 0, NOP);

      // Reset state
      #2;
      check("rst_ready", {31'd0, bus.id_ready}, 32'd0);
      check("rst_flush", {31'd0, bus.flush_out}, 32'd0);
      check("rst_busy", {31'd0, bus.sb_busy}, 32'd0);
      check("rst_stall", bus.stall_cnt, 32'd0);
      cyc();
      rst_n = 1'b1;
      #1 check("ready_before_clk", {31'd0, bus.id_ready}, 32'd0);

      // 1) RAW on x5, no same-cycle WB bypass
      cyc(); id_drive(1, 0, 0, 0, 0, 1, 5, NOP);
      #1 check("t1_issue_x5", {31'd0, bus.id_ready}, 32'd1);
      cyc(); id_drive(1, 1, 5, 0, 0, 0, 0, NOP);
      #1 check("t1_raw_stall_a", {31'd0, bus.id_ready}, 32'd0);
      check("t1_busy", {31'd0, bus.sb_busy}, 32'd1);
      cyc();
      #1 check("t1_raw_stall_b", {31'd0, bus.id_ready}, 32'd0);
      cyc(); wb_drive(1, 1, 5, NOP);
      #1 check("t1_no_bypass", {31'd0, bus.id_ready}, 32'd0);
      cyc(); wb_drive(0, 0, 0, NOP);
      #1 check("t1_after_retire", {31'd0, bus.id_ready}, 32'd1);
      cyc(); id_drive(0, 0, 0, 0, 0, 0, 0, NOP);
      #1 check("t1_idle_busy", {31'd0, bus.sb_busy}, 32'd0);
      check("t1_stall_cnt", bus.stall_cnt, EXP_T1_STALLS);

      // 2) x0-only traffic never stalls and never marks busy
      for (int i = 0; i < 3; i++) begin
         cyc(); id_drive(1, 1, 0, 1, 0, 1, 0, NOP);
         #1 check("t2_x0_ready", {31'd0, bus.id_ready}, 32'd1);
         check("t2_x0_busy", {31'd0, bus.sb_busy}, 32'd0);
      end

      // 3) Saturation: three writes to x7 in flight, fourth waits for a retire
      for (int i = 0; i < 3; i++) begin
         cyc(); id_drive(1, 0, 0, 0, 0, 1, 7, NOP);
         #1 check("t3_write_x7", {31'd0, bus.id_ready}, 32'd1);
      end
      cyc();
      #1 check("t3_sat_stall", {31'd0, bus.id_ready}, 32'd0);
      wb_drive(1, 1, 7, NOP);
      #1 check("t3_sat_retire_same_cycle", {31'd0, bus.id_ready}, 32'd0);
      cyc(); wb_drive(0, 0, 0, NOP);
      #1 check("t3_fourth_issues", {31'd0, bus.id_ready}, 32'd1);
      cyc(); id_drive(0, 0, 0, 0, 0, 0, 0, NOP);
      for (int i = 0; i < 3; i++) begin
         wb_drive(1, 1, 7, NOP);
         cyc();
      end
      wb_drive(0, 0, 0, NOP);
      #1 check("t3_drained_busy", {31'd0, bus.sb_busy}, 32'd0);

      // 4) Issue x3 and retire x3 in the same cycle: count stays at 1
      cyc(); id_drive(1, 0, 0, 0, 0, 1, 3, NOP);
      #1 check("t4_first_x3", {31'd0, bus.id_ready}, 32'd1);
      cyc(); wb_drive(1, 1, 3, NOP);
      #1 check("t4_second_x3", {31'd0, bus.id_ready}, 32'd1);
      cyc(); wb_drive(0, 0, 0, NOP); id_drive(0, 1, 3, 0, 0, 0, 0, NOP);
      #1 check("t4_pend_kept_raw", {31'd0, bus.id_ready}, 32'd0);
      check("t4_busy", {31'd0, bus.sb_busy}, 32'd1);
      cyc(); wb_drive(1, 1, 3, NOP);
      cyc(); wb_drive(0, 0, 0, NOP); id_drive(1, 0, 0, 1, 3, 0, 0, NOP);
      #1 check("t4_cleared_ready", {31'd0, bus.id_ready}, 32'd1);
      check("t4_cleared_busy", {31'd0, bus.sb_busy}, 32'd0);

      // 5) ecall: HOLD until trap reaches WB, then a single flush cycle
      cyc(); id_drive(1, 0, 0, 0, 0, 1, 4, NOP);
      #1 check("t5_write_x4", {31'd0, bus.id_ready}, 32'd1);
      cyc(); id_drive(1, 0, 0, 0, 0, 1, 10, ECALL);
      #1 check("t5_ecall_issue", {31'd0, bus.id_ready}, 32'd1);
      cyc(); id_drive(1, 0, 0, 0, 0, 1, 11, NOP);
      #1 check("t5_hold_ready", {31'd0, bus.id_ready}, 32'd0);
      check("t5_hold_flush", {31'd0, bus.flush_out}, 32'd0);
      check("t5_hold_busy", {31'd0, bus.sb_busy}, 32'd1);
      cyc(); wb_drive(1, 0, 0, ECALL);
      #1 check("t5_flush_not_yet", {31'd0, bus.flush_out}, 32'd0);
      cyc(); wb_drive(0, 0, 0, NOP);
      #1 check("t5_flush_pulse", {31'd0, bus.flush_out}, 32'd1);
      check("t5_flush_ready", {31'd0, bus.id_ready}, 32'd0);
      cyc(); id_drive(1, 1, 4, 0, 0, 0, 0, NOP);
      #1 check("t5_flush_done", {31'd0, bus.flush_out}, 32'd0);
      check("t5_counters_clear", {31'd0, bus.sb_busy}, 32'd0);
      check("t5_x4_readable", {31'd0, bus.id_ready}, 32'd1);

      // 5b) Trap raised at WB while in RUN flushes directly
      cyc(); id_drive(1, 0, 0, 0, 0, 1, 6, NOP);
      cyc(); id_drive(0, 0, 0, 0, 0, 0, 0, NOP); wb_drive(1, 0, 0, MEMF);
      #1 check("t5b_busy_before", {31'd0, bus.sb_busy}, 32'd1);
      cyc(); wb_drive(0, 0, 0, NOP);
      #1 check("t5b_flush_pulse", {31'd0, bus.flush_out}, 32'd1);
      cyc();
      #1 check("t5b_flush_once", {31'd0, bus.flush_out}, 32'd0);
      check("t5b_busy_after", {31'd0, bus.sb_busy}, 32'd0);

      // 6) Reset during HOLD with two writes to x9 pending
      cyc(); id_drive(1, 0, 0, 0, 0, 1, 9, NOP);
      cyc();
      cyc(); id_drive(1, 0, 0, 0, 0, 0, 0, ECALL);
      cyc(); id_drive(0, 0, 0, 0, 0, 0, 0, NOP);
      #1 check("t6_hold_busy", {31'd0, bus.sb_busy}, 32'd1);
      check("t6_hold_ready", {31'd0, bus.id_ready}, 32'd0);
      #1 rst_n = 1'b0;
      #1 check("t6_rst_flush", {31'd0, bus.flush_out}, 32'd0);
      check("t6_rst_busy", {31'd0, bus.sb_busy}, 32'd0);
      check("t6_rst_ready", {31'd0, bus.id_ready}, 32'd0);
      check("t6_rst_stall", bus.stall_cnt, 32'd0);
      cyc(); rst_n = 1'b1;
      cyc(); id_drive(1, 1, 9, 0, 0, 1, 9, NOP);
      #1 check("t6_x9_clear_ready", {31'd0, bus.id_ready}, 32'd1);
      check("t6_flush_none", {31'd0, bus.flush_out}, 32'd0);
      cyc(); id_drive(0, 0, 0, 0, 0, 0, 0, NOP);
      #1 check("t6_x9_counted", {31'd0, bus.sb_busy}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
